// File: rtl/idelay_tap_arbiter_if.sv
// Request/ack and IDELAY control bundle between the tap-step requesters and the arbiter.
// slave = arbiter side, master = requester/IDELAY side.
interface idelay_tap_arbiter_if #(
  parameter int unsigned NUM_CHAN = 5
);
  logic                    train_req;
  logic [2:0]              train_chan;
  logic                    train_inc;
  logic                    train_ack;
  logic                    ext_req;
  logic [2:0]              ext_chan;
  logic                    ext_inc;
  logic                    ext_ack;
  logic [NUM_CHAN-1:0]     dlyce;
  logic [NUM_CHAN-1:0]     dlyinc;
  logic [5*NUM_CHAN-1:0]   tap_value;
  logic                    busy;
  logic                    cmd_err;

  modport slave (
    input  train_req, train_chan, train_inc,
    input  ext_req, ext_chan, ext_inc,
    output train_ack, ext_ack,
    output dlyce, dlyinc, tap_value, busy, cmd_err
  );

  modport master (
    output train_req, train_chan, train_inc,
    output ext_req, ext_chan, ext_inc,
    input  train_ack, ext_ack,
    input  dlyce, dlyinc, tap_value, busy, cmd_err
  );
endinterface

// File: rtl/idelay_tap_arbiter.sv
// Round-robin arbiter stepping per-channel IDELAY taps; CE one cycle after grant, then SETTLE_CYC idle.
// Requests are held until ack and sampled only in IDLE; out-of-range steps are acked with cmd_err.
module idelay_tap_arbiter #(
  parameter int unsigned NUM_CHAN   = 5,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned TAP_MAX    = 31
) (
  input  logic                  clkdiv,
  input  logic                  rst,
  idelay_tap_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    REJECT = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                chan_q, chan_d;
  logic                      inc_q, inc_d;
  logic                      who_ext_q, who_ext_d;
  logic                      last_ext_q, last_ext_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [NUM_CHAN-1:0][4:0]  tap_q, tap_d;

  logic                      any_req;
  logic                      grant_ext;
  logic [2:0]                req_chan;
  logic                      req_inc;
  logic [4:0]                req_tap;
  logic                      req_bad;

  logic [NUM_CHAN-1:0]       dlyce_o;
  logic [NUM_CHAN-1:0]       dlyinc_o;
  logic                      train_ack_o;
  logic                      ext_ack_o;
  logic                      cmd_err_o;

  // Tie goes to whichever requester was not granted last.
  always_comb begin
    any_req   = bus.train_req | bus.ext_req;
    grant_ext = bus.ext_req & (~bus.train_req | ~last_ext_q);
    req_chan  = grant_ext ? bus.ext_chan : bus.train_chan;
    req_inc   = grant_ext ? bus.ext_inc  : bus.train_inc;
    req_tap   = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (req_chan == 3'(i)) req_tap = tap_q[i];
    end
    req_bad = ({29'd0, req_chan} >= NUM_CHAN) ||
              ( req_inc && (req_tap == 5'(TAP_MAX))) ||
              (!req_inc && (req_tap == 5'd0));
  end

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    inc_d       = inc_q;
    who_ext_d   = who_ext_q;
    last_ext_d  = last_ext_q;
    cnt_d       = cnt_q;
    tap_d       = tap_q;
    dlyce_o     = '0;
    dlyinc_o    = '0;
    train_ack_o = 1'b0;
    ext_ack_o   = 1'b0;
    cmd_err_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          chan_d     = req_chan;
          inc_d      = req_inc;
          who_ext_d  = grant_ext;
          last_ext_d = grant_ext;
          state_d    = req_bad ? REJECT : ISSUE;
        end
      end

      ISSUE: begin
        // Channel range and tap limits were validated at grant.
        for (int i = 0; i < NUM_CHAN; i++) begin
          if (chan_q == 3'(i)) begin
            dlyce_o[i]  = 1'b1;
            dlyinc_o[i] = inc_q;
            tap_d[i]    = inc_q ? (tap_q[i] + 5'd1) : (tap_q[i] - 5'd1);
          end
        end
        train_ack_o = ~who_ext_q;
        ext_ack_o   = who_ext_q;
        cnt_d       = 8'(SETTLE_CYC);
        state_d     = SETTLE;
      end

      SETTLE: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      REJECT: begin
        train_ack_o = ~who_ext_q;
        ext_ack_o   = who_ext_q;
        cmd_err_o   = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      chan_q     <= '0;
      inc_q      <= 1'b0;
      who_ext_q  <= 1'b0;
      last_ext_q <= 1'b1;
      cnt_q      <= '0;
      tap_q      <= '0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      inc_q      <= inc_d;
      who_ext_q  <= who_ext_d;
      last_ext_q <= last_ext_d;
      cnt_q      <= cnt_d;
      tap_q      <= tap_d;
    end
  end

  assign bus.dlyce     = dlyce_o;
  assign bus.dlyinc    = dlyinc_o;
  assign bus.train_ack = train_ack_o;
  assign bus.ext_ack   = ext_ack_o;
  assign bus.cmd_err   = cmd_err_o;
  assign bus.busy      = (state_q != IDLE);
  assign bus.tap_value = tap_q;

endmodule

// File: tb/tb_idelay_tap_arbiter.sv
// Directed bench for idelay_tap_arbiter: grant latency, round-robin, tap limits, bad channel, reset abort.
module tb_idelay_tap_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idelay_tap_arbiter_if #(.NUM_CHAN(5)) bus ();

  idelay_tap_arbiter #(
    .NUM_CHAN  (5),
    .SETTLE_CYC(8),
    .TAP_MAX   (31)
  ) dut (
    .clkdiv(clk),
    .rst   (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] get_tap(input int ch);
    return bus.tap_value[5*ch +: 5];
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_dlyce"},  32'(bus.dlyce),     32'd0);
    check_val({tag, "_dlyinc"}, 32'(bus.dlyinc),    32'd0);
    check_val({tag, "_tacks"},  32'({bus.train_ack, bus.ext_ack}), 32'd0);
    check_val({tag, "_err"},    32'(bus.cmd_err),   32'd0);
    check_val({tag, "_busy"},   32'(bus.busy),      32'd0);
    check_val({tag, "_taps"},   32'(bus.tap_value), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raises one request, waits for its ack, samples the control outputs in the ack cycle, drops req.
  task automatic do_req(input bit use_ext, input logic [2:0] ch, input bit inc,
                        output int lat, output logic [4:0] ce, output logic [4:0] dinc,
                        output logic err, output logic other_ack);
    logic ack;
    if (use_ext) begin
      bus.ext_req = 1'b1; bus.ext_chan = ch; bus.ext_inc = inc;
    end else begin
      bus.train_req = 1'b1; bus.train_chan = ch; bus.train_inc = inc;
    end
    lat = 0;
    ack = 1'b0;
    while (!ack && lat < 20) begin
      @(negedge clk);
      lat++;
      ack = use_ext ? bus.ext_ack : bus.train_ack;
    end
    if (!ack) lat = 99;
    ce        = bus.dlyce;
    dinc      = bus.dlyinc;
    err       = bus.cmd_err;
    other_ack = use_ext ? bus.train_ack : bus.ext_ack;
    bus.train_req = 1'b0;
    bus.ext_req   = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Both requesters on ch0 increment; each drops its request on seeing its ack.
  task automatic tie(output bit first_ext, output int gap, output int overlap);
    int tc, ec, c;
    tc = -1; ec = -1; c = 0; overlap = 0;
    bus.train_req = 1'b1; bus.train_chan = 3'd0; bus.train_inc = 1'b1;
    bus.ext_req   = 1'b1; bus.ext_chan   = 3'd0; bus.ext_inc   = 1'b1;
    while ((tc < 0 || ec < 0) && c < 60) begin
      @(negedge clk);
      c++;
      if (bus.train_ack && bus.ext_ack) overlap++;
      if (bus.train_ack) begin tc = c; bus.train_req = 1'b0; end
      if (bus.ext_ack)   begin ec = c; bus.ext_req   = 1'b0; end
    end
    bus.train_req = 1'b0;
    bus.ext_req   = 1'b0;
    first_ext = (ec >= 0) && (tc < 0 || ec < tc);
    gap = (tc < 0 || ec < 0) ? -1 : (first_ext ? tc - ec : ec - tc);
  endtask

  int         lat, n;
  logic [4:0] ce, dinc;
  logic       err, oth;
  bit         first_ext;
  int         gap, ovl;

  initial begin
    rst = 1'b1;
    bus.train_req = 1'b0; bus.train_chan = 3'd0; bus.train_inc = 1'b0;
    bus.ext_req   = 1'b0; bus.ext_chan   = 3'd0; bus.ext_inc   = 1'b0;

    // Single train increment on ch2; first grant right after reset release.
    do_reset();
    do_req(1'b0, 3'd2, 1'b1, lat, ce, dinc, err, oth);
    check_val("inc2_lat",    32'(lat),  32'd1);
    check_val("inc2_dlyce",  32'(ce),   32'b00100);
    check_val("inc2_dlyinc", 32'(dinc), 32'b00100);
    check_val("inc2_err",    32'(err),  32'd0);
    check_val("inc2_oack",   32'(oth),  32'd0);
    wait_idle(n);
    check_val("inc2_busy",   32'(n),    32'd9);
    check_val("inc2_tap",    32'(get_tap(2)), 32'd1);

    // Decrement ch2 back to 0: CE without INC.
    do_req(1'b0, 3'd2, 1'b0, lat, ce, dinc, err, oth);
    check_val("dec2_dlyce",  32'(ce),   32'b00100);
    check_val("dec2_dlyinc", 32'(dinc), 32'd0);
    wait_idle(n);
    check_val("dec2_tap",    32'(get_tap(2)), 32'd0);

    // Train was granted last, so ext wins this tie.
    tie(first_ext, gap, ovl);
    check_val("rr_ext_first", 32'(first_ext), 32'd1);
    check_val("rr_ext_gap",   32'(gap),       32'd10);
    check_val("rr_ext_ovl",   32'(ovl),       32'd0);
    wait_idle(n);
    check_val("rr_ext_tap0",  32'(get_tap(0)), 32'd2);

    // After reset the pointer is ext, so train wins.
    do_reset();
    tie(first_ext, gap, ovl);
    check_val("rr_trn_first", 32'(first_ext), 32'd0);
    check_val("rr_trn_gap",   32'(gap),       32'd10);
    check_val("rr_trn_ovl",   32'(ovl),       32'd0);
    wait_idle(n);
    check_val("rr_trn_tap0",  32'(get_tap(0)), 32'd2);

    // Decrement at tap 0 is rejected.
    do_req(1'b1, 3'd1, 1'b0, lat, ce, dinc, err, oth);
    check_val("rej0_lat",   32'(lat), 32'd1);
    check_val("rej0_err",   32'(err), 32'd1);
    check_val("rej0_dlyce", 32'(ce),  32'd0);
    check_val("rej0_oack",  32'(oth), 32'd0);
    wait_idle(n);
    check_val("rej0_busy",  32'(n),   32'd1);
    check_val("rej0_tap",   32'(get_tap(1)), 32'd0);

    // Walk ch4 to the top tap, then one more is rejected.
    for (int k = 0; k < 31; k++) begin
      do_req(1'b0, 3'd4, 1'b1, lat, ce, dinc, err, oth);
      check_val("walk_err", 32'(err), 32'd0);
      check_val("walk_ce",  32'(ce),  32'b10000);
      wait_idle(n);
    end
    check_val("walk_tap31", 32'(get_tap(4)), 32'd31);
    do_req(1'b0, 3'd4, 1'b1, lat, ce, dinc, err, oth);
    check_val("max_err",   32'(err), 32'd1);
    check_val("max_dlyce", 32'(ce),  32'd0);
    wait_idle(n);
    check_val("max_busy",  32'(n),   32'd1);
    check_val("max_tap",   32'(get_tap(4)), 32'd31);

    // Channel index beyond NUM_CHAN.
    do_req(1'b0, 3'd5, 1'b1, lat, ce, dinc, err, oth);
    check_val("ch5_err",   32'(err), 32'd1);
    check_val("ch5_dlyce", 32'(ce),  32'd0);
    wait_idle(n);
    check_val("ch5_busy",  32'(n),   32'd1);
    check_val("ch5_taps",  32'(bus.tap_value), {7'd0, 5'd31, 15'd0, 5'd2});

    // Reset mid-SETTLE aborts and clears taps.
    do_req(1'b0, 3'd3, 1'b1, lat, ce, dinc, err, oth);
    check_val("abort_ce", 32'(ce), 32'b01000);
    @(negedge clk);
    @(negedge clk);
    check_val("abort_busy_pre", 32'(bus.busy), 32'd1);
    check_val("abort_tap_pre",  32'(get_tap(3)), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 3'd3, 1'b1, lat, ce, dinc, err, oth);
    check_val("post_lat", 32'(lat), 32'd1);
    check_val("post_ce",  32'(ce),  32'b01000);
    check_val("post_err", 32'(err), 32'd0);
    wait_idle(n);
    check_val("post_busy", 32'(n), 32'd9);
    check_val("post_tap",  32'(get_tap(3)), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
